bit_addmul_acc: RTL and testbench

BIT_ADDMUL_ACC -- requirements
Module: bit_addmul_acc

---
 rtl/bitpack_pkg.sv | 22 ++
 rtl/bit_lfsr.sv | 26 ++
 rtl/bit_addmul_acc.sv | 161 ++++++++++++++++
 tb/tb_bit_addmul_acc.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bitpack_pkg.sv
// Shared types and constants for the bitstream add/multiply accumulator:
// the run-control state encoding and the 16-bit LFSR width, taps and step.
package bitpack_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int LFSR_W = 16;

    // Fibonacci taps 16,14,13,11 -> bits 15,13,12,10
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    function automatic logic [LFSR_W-1:0] lfsr_step(
        input logic [LFSR_W-1:0] s
    );
        return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/bit_lfsr.sv
// 16-bit maximal-length Fibonacci LFSR, advances when i_adv is high.
// Ports: i_clk, i_rst_n (async, low), i_adv, o_state (current value).
module bit_lfsr
    import bitpack_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_adv,
    output logic [LFSR_W-1:0] o_state
);

    logic [LFSR_W-1:0] r_state;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= SEED;
        end else if (i_adv) begin
            r_state <= lfsr_step(r_state);
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/bit_addmul_acc.sv
// Stochastic bitstream multiply (AND) and scaled add (mux) with run counters.
// Ports: CLK, RSTN (async, low), START/LEN start a run of LEN valid cycles;
//   IN_VALID/A/SEL feed the bit path; PROD/AVG/BIT_VALID registered bits;
//   BUSY (RUN), DONE (counts valid) + OUT_READY; CNT_PROD, CNT_AVG counts.
// Macro BIT_ADDMUL_LFSR_SEL_EN: AVG select comes from an internal LFSR
//   instead of SEL (SEL is then ignored but still present).
module bit_addmul_acc
    import bitpack_pkg::*;
#(
    parameter int          N_IN  = 4,
    parameter int          LEN_W = 8,
    parameter logic [15:0] SEED  = 16'hACE1
) (
    input  logic                    CLK,
    input  logic                    RSTN,
    input  logic                    START,
    input  logic [LEN_W-1:0]        LEN,
    input  logic                    IN_VALID,
    input  logic [N_IN-1:0]         A,
    input  logic [$clog2(N_IN)-1:0] SEL,
    output logic                    PROD,
    output logic                    AVG,
    output logic                    BIT_VALID,
    output logic                    BUSY,
    output logic                    DONE,
    input  logic                    OUT_READY,
    output logic [LEN_W-1:0]        CNT_PROD,
    output logic [LEN_W-1:0]        CNT_AVG
);

    localparam int SEL_W = $clog2(N_IN);

    if (N_IN < 2 || N_IN > 16 || (N_IN & (N_IN - 1)) != 0) begin : g_bad_n_in
        $error("bit_addmul_acc: N_IN must be a power of two in 2..16");
    end

    if (SEED == 16'h0000) begin : g_bad_seed
        $error("bit_addmul_acc: SEED must be non-zero");
    end

    logic [SEL_W-1:0] w_idx;

`ifdef BIT_ADDMUL_LFSR_SEL_EN
    logic [LFSR_W-1:0] w_lfsr;
    logic              w_unused;

    bit_lfsr #(
        .SEED (SEED)
    ) u_lfsr (
        .i_clk   (CLK),
        .i_rst_n (RSTN),
        .i_adv   (IN_VALID),
        .o_state (w_lfsr)
    );

    assign w_idx    = w_lfsr[SEL_W-1:0];
    assign w_unused = ^{SEL, w_lfsr[LFSR_W-1:SEL_W]};
`else
    assign w_idx = SEL;
`endif

    logic w_pbit;
    logic w_abit;

    assign w_pbit = &A;
    assign w_abit = A[w_idx];

    logic r_prod;
    logic r_avg;
    logic r_bv;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_prod <= 1'b0;
            r_avg  <= 1'b0;
            r_bv   <= 1'b0;
        end else begin
            r_bv <= IN_VALID;
            if (IN_VALID) begin
                r_prod <= w_pbit;
                r_avg  <= w_abit;
            end
        end
    end

    state_t           r_state;
    state_t           w_state_nxt;
    logic [LEN_W-1:0] r_rem;
    logic [LEN_W-1:0] w_rem_nxt;
    logic [LEN_W-1:0] r_cp;
    logic [LEN_W-1:0] w_cp_nxt;
    logic [LEN_W-1:0] r_ca;
    logic [LEN_W-1:0] w_ca_nxt;
    logic             w_load;

    // A new run may begin from IDLE, or straight out of DONE when the
    // counts are being accepted in the same cycle.
    assign w_load = START &
                    ((r_state == ST_IDLE) ||
                     ((r_state == ST_DONE) && OUT_READY));

    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        w_cp_nxt    = r_cp;
        w_ca_nxt    = r_ca;
        if (w_load) begin
            w_rem_nxt   = LEN;
            w_cp_nxt    = '0;
            w_ca_nxt    = '0;
            w_state_nxt = (LEN != '0) ? ST_RUN : ST_DONE;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (IN_VALID) begin
                        w_cp_nxt  = r_cp + LEN_W'(w_pbit);
                        w_ca_nxt  = r_ca + LEN_W'(w_abit);
                        w_rem_nxt = r_rem - LEN_W'(1);
                        if (r_rem == LEN_W'(1)) begin
                            w_state_nxt = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (OUT_READY) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    w_state_nxt = ST_IDLE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state <= ST_IDLE;
            r_rem   <= '0;
            r_cp    <= '0;
            r_ca    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
            r_cp    <= w_cp_nxt;
            r_ca    <= w_ca_nxt;
        end
    end

    assign PROD      = r_prod;
    assign AVG       = r_avg;
    assign BIT_VALID = r_bv;
    assign BUSY      = (r_state == ST_RUN);
    assign DONE      = (r_state == ST_DONE);
    assign CNT_PROD  = r_cp;
    assign CNT_AVG   = r_ca;

endmodule

// File: tb/tb_bit_addmul_acc.sv
// Randomized self-checking bench for bit_addmul_acc (N_IN=4 and N_IN=8).
// Honours BIT_ADDMUL_LFSR_SEL_EN in its reference model.
module tb_bit_addmul_acc;

    localparam logic [15:0] SEED = 16'hACE1;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic       start, in_valid, out_ready;
    logic [7:0] len;
    logic [3:0] a;
    logic [1:0] sel;
    logic       prod, avg, bit_valid, busy, done;
    logic [7:0] cnt_prod, cnt_avg;

    logic       s8_start, s8_valid, s8_ready;
    logic [7:0] s8_len, s8_a;
    logic [2:0] s8_sel;
    logic       s8_prod, s8_avg, s8_bv, s8_busy, s8_done;
    logic [7:0] s8_cp, s8_ca;

    bit_addmul_acc #(.N_IN(4), .LEN_W(8), .SEED(SEED)) u_dut (
        .CLK(clk), .RSTN(rstn), .START(start), .LEN(len),
        .IN_VALID(in_valid), .A(a), .SEL(sel),
        .PROD(prod), .AVG(avg), .BIT_VALID(bit_valid),
        .BUSY(busy), .DONE(done), .OUT_READY(out_ready),
        .CNT_PROD(cnt_prod), .CNT_AVG(cnt_avg)
    );

    bit_addmul_acc #(.N_IN(8), .LEN_W(8), .SEED(SEED)) u_dut8 (
        .CLK(clk), .RSTN(rstn), .START(s8_start), .LEN(s8_len),
        .IN_VALID(s8_valid), .A(s8_a), .SEL(s8_sel),
        .PROD(s8_prod), .AVG(s8_avg), .BIT_VALID(s8_bv),
        .BUSY(s8_busy), .DONE(s8_done), .OUT_READY(s8_ready),
        .CNT_PROD(s8_cp), .CNT_AVG(s8_ca)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        logic fb;
        fb = s[15] ^ s[13] ^ s[12] ^ s[10];
        return {s[14:0], fb};
    endfunction

    // Reference bit path: one-cycle-delayed AND / selected bit.
    logic [15:0] m_lfsr4;
    logic        m_prod, m_avg, m_bv;

    function automatic logic [1:0] cur_idx4();
`ifdef BIT_ADDMUL_LFSR_SEL_EN
        return m_lfsr4[1:0];
`else
        return sel;
`endif
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_lfsr4 = SEED;
            m_prod  = 1'b0;
            m_avg   = 1'b0;
            m_bv    = 1'b0;
        end else begin
            m_bv = in_valid;
            if (in_valid) begin
                m_prod  = &a;
                m_avg   = a[cur_idx4()];
                m_lfsr4 = lfsr_next(m_lfsr4);
            end
        end
    end

    always @(negedge clk) begin
        if (rstn) begin
            chk("bit_valid", bit_valid, m_bv);
            chk("prod", prod, m_prod);
            chk("avg", avg, m_avg);
        end
    end

    task automatic run4(input int ln, input int vmode, input bit arand,
                        input logic [3:0] afix, input logic [1:0] sfix,
                        input bit ack, input int exp_cyc, input string tag,
                        output int ep, output int ea);
        int rem, k;
        bit early;
        logic v;
        @(negedge clk);
        start = 1'b1; len = ln[7:0]; out_ready = ack;
        in_valid = 1'b0; a = afix; sel = sfix;
        rem = ln; k = 0; ep = 0; ea = 0; early = 0;
        @(negedge clk);
        start = 1'b0; out_ready = 1'b0;
        chk({tag, "_busy1"}, busy, (ln != 0));
        while (rem > 0 && k < 2000) begin
            k++;
            case (vmode)
                0:       v = 1'b1;
                1:       v = k[0];
                default: v = 1'($urandom_range(0, 1));
            endcase
            in_valid = v;
            if (arand) begin
                a = 4'($urandom);
                sel = 2'($urandom);
                start = 1'($urandom_range(0, 1));
            end else begin
                a = afix;
                sel = sfix;
            end
            if (v) begin
                ep += int'(&a);
                ea += int'(a[cur_idx4()]);
                rem--;
            end
            @(negedge clk);
            if (rem > 0 && done) early = 1;
        end
        in_valid = 1'b0; start = 1'b0;
        chk({tag, "_early"}, early, 0);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_cprod"}, cnt_prod, ep);
        chk({tag, "_cavg"}, cnt_avg, ea);
        if (exp_cyc > 0) chk({tag, "_cyc"}, k + 1, exp_cyc);
    endtask

    task automatic ack4(input int hold, input int ep, input int ea);
        repeat (hold) begin
            in_valid = 1'($urandom_range(0, 1));
            a = 4'($urandom);
            start = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("hold_done", done, 1);
            chk("hold_cprod", cnt_prod, ep);
            chk("hold_cavg", cnt_avg, ea);
        end
        start = 1'b0; out_ready = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        chk("ack_done", done, 0);
        chk("ack_busy", busy, 0);
    endtask

    task automatic noise(input int n);
        repeat (n) begin
            in_valid = 1'($urandom_range(0, 1));
            a = 4'($urandom);
            sel = 2'($urandom);
            start = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int ep, ea;
        logic [2:0] idx8;
`ifdef BIT_ADDMUL_LFSR_SEL_EN
        logic [15:0] l8;
`endif
        rstn = 1'b0; start = 0; len = 0; in_valid = 0; a = 0; sel = 0;
        out_ready = 0;
        s8_start = 0; s8_len = 0; s8_valid = 0; s8_a = 0; s8_sel = 0;
        s8_ready = 0;
        repeat (2) @(negedge clk);
        chk("rst_prod", prod, 0);
        chk("rst_bv", bit_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cnt", {cnt_prod, cnt_avg}, 0);
        rstn = 1'b1;
        @(negedge clk);

        // N_IN=8, A=1, LEN=255: AVG count = samples whose index is 0.
`ifdef BIT_ADDMUL_LFSR_SEL_EN
        l8 = SEED;
`endif
        s8_start = 1'b1; s8_len = 8'd255;
        @(negedge clk);
        s8_start = 1'b0; ea = 0;
        for (int i = 0; i < 255; i++) begin
            s8_valid = 1'b1; s8_a = 8'h01; s8_sel = 3'd0;
`ifdef BIT_ADDMUL_LFSR_SEL_EN
            idx8 = l8[2:0];
            l8 = lfsr_next(l8);
`else
            idx8 = s8_sel;
`endif
            if (idx8 == 3'd0) ea++;
            @(negedge clk);
        end
        s8_valid = 1'b0;
        chk("n8_done", s8_done, 1);
        chk("n8_cprod", s8_cp, 0);
        chk("n8_cavg", s8_ca, ea);
        s8_ready = 1'b1;
        @(negedge clk);
        s8_ready = 1'b0;
        chk("n8_idle", s8_done, 0);

        run4(8, 0, 0, 4'b1111, 2'd2, 0, 9, "all1", ep, ea);
        ack4(2, ep, ea);

        run4(10, 1, 0, 4'b0101, 2'd0, 0, 20, "tog", ep, ea);
        ack4(1, ep, ea);

        run4(0, 0, 0, 4'b0000, 2'd0, 0, 1, "len0", ep, ea);
        chk("len0_zero", {cnt_prod, cnt_avg}, 0);
        run4(3, 0, 1, 4'b0000, 2'd1, 1, 4, "b2b", ep, ea);
        ack4(1, ep, ea);

        // Reset mid-run after 5 of 8 bits.
        @(negedge clk);
        start = 1'b1; len = 8'd8;
        @(negedge clk);
        start = 1'b0;
        repeat (5) begin
            in_valid = 1'b1; a = 4'b1111;
            @(negedge clk);
        end
        in_valid = 1'b0;
        #2 rstn = 1'b0;
        #1;
        chk("mrst_prod", prod, 0);
        chk("mrst_avg", avg, 0);
        chk("mrst_bv", bit_valid, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_done", done, 0);
        chk("mrst_cprod", cnt_prod, 0);
        chk("mrst_cavg", cnt_avg, 0);
        @(negedge clk);
        #2 rstn = 1'b1;
        @(negedge clk);
        chk("mrst_idle", {busy, done}, 0);
        run4(8, 2, 1, 4'b0000, 2'd3, 0, 0, "fresh", ep, ea);
        ack4(1, ep, ea);

        for (int r = 0; r < 12; r++) begin
            noise($urandom_range(0, 4));
            run4($urandom_range(1, 20), 2, 1, 4'b0000, 2'd0, 0, 0,
                 "rnd", ep, ea);
            ack4($urandom_range(0, 3), ep, ea);
        end
        noise(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
